// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Bundles the instruction fields, datapath status and control strobes that
//   pass between the multicycle controller and its datapath.
//   master : controller side (samples op/funct3/funct7b5/zero/memReady,
//            drives every control output and the debug state code)
//   slave  : datapath side (the mirror image)
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       memReady;

  logic       memReq;
  logic       memWrite;
  logic       adrSrc;
  logic       irWrite;
  logic       pcWrite;
  logic       regWrite;
  logic [1:0] resultSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] immSrc;
  logic [3:0] aluControl;
  logic       illegalInstr;
  logic [3:0] stateOut;

  modport master (
    input  op, funct3, funct7b5, zero, memReady,
    output memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, immSrc, aluControl,
           illegalInstr, stateOut
  );

  modport slave (
    output op, funct3, funct7b5, zero, memReady,
    input  memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, immSrc, aluControl,
           illegalInstr, stateOut
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Control FSM for a multicycle RV32 subset core (lw, sw, R/I ALU ops, beq,
//   jal). Moore outputs are registered alongside the state; only irWrite and
//   pcWrite are gated combinationally by memReady (FETCH) and zero (BEQ).
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous, active-high; forces FETCH and clears all strobes
//     bus   - multicycle_control_if.master: instruction fields, zero flag,
//             memReady in; memory/ALU/register-file control and the debug
//             state code out
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd15
  } stateT;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0101;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic       memReq;
    logic       memWrite;
    logic       adrSrc;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] immSrc;
    logic [3:0] aluControl;
    logic       illegalInstr;
  } ctrlT;

  stateT      state;
  stateT      nextState;
  ctrlT       ctrl;
  logic [3:0] aluDecoded;
  logic       aluLegal;

  // Moore control word for a state. isStore and alu only matter for the
  // states whose outputs depend on the latched instruction.
  function automatic ctrlT ctrlFor(stateT s, logic isStore, logic [3:0] alu);
    ctrlT c;
    c = '0;
    case (s)
      FETCH: begin
        c.memReq    = 1'b1;
        c.aluSrcB   = 2'b10;
        c.resultSrc = 2'b10;
      end
      DECODE: begin
        c.aluSrcA = 2'b01;
        c.aluSrcB = 2'b01;
        c.immSrc  = 2'b10;
      end
      MEMADR: begin
        c.aluSrcA = 2'b10;
        c.aluSrcB = 2'b01;
        c.immSrc  = isStore ? 2'b01 : 2'b00;
      end
      MEMREAD: begin
        c.memReq = 1'b1;
        c.adrSrc = 1'b1;
      end
      MEMWB: begin
        c.resultSrc = 2'b01;
        c.regWrite  = 1'b1;
      end
      MEMWRITE: begin
        c.memReq   = 1'b1;
        c.adrSrc   = 1'b1;
        c.memWrite = 1'b1;
      end
      EXECUTER: begin
        c.aluSrcA    = 2'b10;
        c.aluControl = alu;
      end
      EXECUTEI: begin
        c.aluSrcA    = 2'b10;
        c.aluSrcB    = 2'b01;
        c.aluControl = alu;
      end
      ALUWB: c.regWrite = 1'b1;
      BEQ: begin
        c.aluSrcA    = 2'b10;
        c.aluControl = ALU_SUB;
      end
      JAL: begin
        c.aluSrcA = 2'b01;
        c.aluSrcB = 2'b10;
        c.immSrc  = 2'b11;
      end
      ILLEGAL: c.illegalInstr = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // R/I ALU decode; funct7b5 only distinguishes SUB (R-type) and guards SLL.
  always_comb begin
    aluLegal   = 1'b1;
    aluDecoded = ALU_ADD;
    case (bus.funct3)
      3'b000: aluDecoded = ((bus.op == OP_RTYPE) && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b111: aluDecoded = ALU_AND;
      3'b110: aluDecoded = ALU_OR;
      3'b001: begin
        if (bus.funct7b5) aluLegal = 1'b0;
        else              aluDecoded = ALU_SLL;
      end
      default: aluLegal = 1'b0;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:  if (bus.memReady) nextState = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: nextState = MEMADR;
          OP_RTYPE:  nextState = aluLegal ? EXECUTER : ILLEGAL;
          OP_ITYPE:  nextState = aluLegal ? EXECUTEI : ILLEGAL;
          OP_BRANCH: nextState = (bus.funct3 == 3'b000) ? BEQ : ILLEGAL;
          OP_JAL:    nextState = JAL;
          default:   nextState = ILLEGAL;
        endcase
      end
      MEMADR:   nextState = (bus.op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (bus.memReady) nextState = MEMWB;
      MEMWB:    nextState = FETCH;
      MEMWRITE: if (bus.memReady) nextState = FETCH;
      EXECUTER: nextState = ALUWB;
      EXECUTEI: nextState = ALUWB;
      ALUWB:    nextState = FETCH;
      BEQ:      nextState = FETCH;
      JAL:      nextState = ALUWB;
      ILLEGAL:  nextState = ILLEGAL;
      default:  nextState = ILLEGAL;
    endcase
  end

  // The control word is computed from nextState so it is valid in the same
  // cycle the state register shows that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= ctrlFor(FETCH, 1'b0, ALU_ADD);
    end else begin
      state <= nextState;
      ctrl  <= ctrlFor(nextState, bus.op == OP_STORE, aluDecoded);
    end
  end

  logic fetchDone;
  // reset is folded in so the FETCH strobes stay low for the whole reset.
  assign fetchDone = (state == FETCH) && bus.memReady && !reset;

  assign bus.memReq       = ctrl.memReq;
  assign bus.memWrite     = ctrl.memWrite;
  assign bus.adrSrc       = ctrl.adrSrc;
  assign bus.regWrite     = ctrl.regWrite;
  assign bus.resultSrc    = ctrl.resultSrc;
  assign bus.aluSrcA      = ctrl.aluSrcA;
  assign bus.aluSrcB      = ctrl.aluSrcB;
  assign bus.immSrc       = ctrl.immSrc;
  assign bus.aluControl   = ctrl.aluControl;
  assign bus.illegalInstr = ctrl.illegalInstr;
  assign bus.irWrite      = fetchDone;
  assign bus.pcWrite      = fetchDone || ((state == BEQ) && bus.zero) || (state == JAL);
  assign bus.stateOut     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Drives instruction sequences (directed cases plus random ones) into
//   multicycle_control. Each cycle the driver pushes the expected output
//   vector into a queue; a monitor on the falling edge pops and compares.
module tb_multicycle_control;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic clk = 1'b0;
  logic reset = 1'b1;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       memReq;
    logic       memWrite;
    logic       adrSrc;
    logic       irWrite;
    logic       pcWrite;
    logic       regWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] immSrc;
    logic [3:0] aluControl;
    logic       illegal;
  } obsT;

  obsT         expQ[$];
  string       tagQ[$];
  int unsigned checks = 0;
  int unsigned fails  = 0;

  logic [6:0] cOp = '0;
  logic [2:0] cF3 = '0;
  logic       cF7 = 1'b0;

  // Expected outputs for one cycle spent in state `code`, straight from the
  // per-state output list; anything not named is zero.
  function automatic obsT expOut(int code, logic mr, logic z, logic [3:0] alu, logic [1:0] imm);
    obsT e;
    e = '0;
    e.st = code[3:0];
    case (code)
      0:  begin e.memReq = 1; e.aluSrcB = 2'b10; e.resultSrc = 2'b10; e.irWrite = mr; e.pcWrite = mr; end
      1:  begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b01; e.immSrc = 2'b10; end
      2:  begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; e.immSrc = imm; end
      3:  begin e.memReq = 1; e.adrSrc = 1; end
      4:  begin e.resultSrc = 2'b01; e.regWrite = 1; end
      5:  begin e.memReq = 1; e.adrSrc = 1; e.memWrite = 1; end
      6:  begin e.aluSrcA = 2'b10; e.aluControl = alu; end
      7:  begin e.aluSrcA = 2'b10; e.aluSrcB = 2'b01; e.aluControl = alu; end
      8:  begin e.regWrite = 1; end
      9:  begin e.aluSrcA = 2'b10; e.aluControl = 4'b0001; e.pcWrite = z; end
      10: begin e.aluSrcA = 2'b01; e.aluSrcB = 2'b10; e.immSrc = 2'b11; e.pcWrite = 1; end
      15: begin e.illegal = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: inputs change 1 time unit after the edge; a reset
  // request rises mid-cycle so the falling-edge check sees its async effect.
  task automatic step(input logic mr, input logic z, input logic rst, input obsT e, input string tag);
    @(posedge clk);
    #1;
    bus.op       = cOp;
    bus.funct3   = cF3;
    bus.funct7b5 = cF7;
    bus.memReady = mr;
    bus.zero     = z;
    if (!rst) reset = 1'b0;
    expQ.push_back(e);
    tagQ.push_back(tag);
    if (rst) begin
      #2;
      reset = 1'b1;
    end
  endtask

  task automatic st(input int code, input logic mr, input logic z, input logic [3:0] alu,
                    input logic [1:0] imm, input string tag);
    step(mr, z, 1'b0, expOut(code, mr, z, alu, imm), tag);
  endtask

  // While reset is high the FSM sits in FETCH with every strobe low.
  task automatic doReset(input int n, input string tag);
    repeat (n) step(rb(), rb(), 1'b1, expOut(0, 1'b0, 1'b0, 4'd0, 2'd0), tag);
  endtask

  // Reference model for one instruction: legality and ALU op from the decode
  // tables, then the state walk with fw fetch stalls and mw memory stalls.
  task automatic runInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input int fw, input int mw, input logic z, input int illHold,
                          input string tag);
    logic       ill;
    logic [3:0] alu;
    ill = 1'b0;
    alu = 4'd0;
    cOp = o; cF3 = f3; cF7 = f7;
    if (o == OP_RTYPE || o == OP_ITYPE) begin
      case (f3)
        3'b000: alu = (o == OP_RTYPE && f7) ? 4'd1 : 4'd0;
        3'b111: alu = 4'd2;
        3'b110: alu = 4'd3;
        3'b001: if (f7) ill = 1'b1; else alu = 4'd5;
        default: ill = 1'b1;
      endcase
    end else if (o == OP_BRANCH) begin
      ill = (f3 != 3'b000);
    end else if (o != OP_LOAD && o != OP_STORE && o != OP_JAL) begin
      ill = 1'b1;
    end

    repeat (fw) st(0, 1'b0, rb(), 4'd0, 2'd0, {tag, "/fetch-wait"});
    st(0, 1'b1, rb(), 4'd0, 2'd0, {tag, "/fetch"});
    st(1, rb(), rb(), 4'd0, 2'd0, {tag, "/decode"});
    if (ill) begin
      repeat (illHold) st(15, rb(), rb(), 4'd0, 2'd0, {tag, "/illegal"});
      doReset(2, {tag, "/reset"});
      return;
    end
    case (o)
      OP_LOAD: begin
        st(2, rb(), rb(), 4'd0, 2'b00, {tag, "/memadr"});
        repeat (mw) st(3, 1'b0, rb(), 4'd0, 2'd0, {tag, "/memread-wait"});
        st(3, 1'b1, rb(), 4'd0, 2'd0, {tag, "/memread"});
        st(4, rb(), rb(), 4'd0, 2'd0, {tag, "/memwb"});
      end
      OP_STORE: begin
        st(2, rb(), rb(), 4'd0, 2'b01, {tag, "/memadr"});
        repeat (mw) st(5, 1'b0, rb(), 4'd0, 2'd0, {tag, "/memwrite-wait"});
        st(5, 1'b1, rb(), 4'd0, 2'd0, {tag, "/memwrite"});
      end
      OP_RTYPE: begin
        st(6, rb(), rb(), alu, 2'd0, {tag, "/executer"});
        st(8, rb(), rb(), 4'd0, 2'd0, {tag, "/aluwb"});
      end
      OP_ITYPE: begin
        st(7, rb(), rb(), alu, 2'd0, {tag, "/executei"});
        st(8, rb(), rb(), 4'd0, 2'd0, {tag, "/aluwb"});
      end
      OP_BRANCH: st(9, rb(), z, 4'd0, 2'd0, {tag, "/beq"});
      default: begin
        st(10, rb(), rb(), 4'd0, 2'd0, {tag, "/jal"});
        st(8, rb(), rb(), 4'd0, 2'd0, {tag, "/aluwb"});
      end
    endcase
  endtask

  // Monitor: one comparison per cycle the driver has described.
  always @(negedge clk) begin
    obsT   a;
    obsT   e;
    string t;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      a.st         = bus.stateOut;
      a.memReq     = bus.memReq;
      a.memWrite   = bus.memWrite;
      a.adrSrc     = bus.adrSrc;
      a.irWrite    = bus.irWrite;
      a.pcWrite    = bus.pcWrite;
      a.regWrite   = bus.regWrite;
      a.resultSrc  = bus.resultSrc;
      a.aluSrcA    = bus.aluSrcA;
      a.aluSrcB    = bus.aluSrcB;
      a.immSrc     = bus.immSrc;
      a.aluControl = bus.aluControl;
      a.illegal    = bus.illegalInstr;
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got st=%0d req=%b we=%b adr=%b ir=%b pc=%b rw=%b res=%b a=%b b=%b imm=%b alu=%b ill=%b, expected st=%0d req=%b we=%b adr=%b ir=%b pc=%b rw=%b res=%b a=%b b=%b imm=%b alu=%b ill=%b",
                 t, a.st, a.memReq, a.memWrite, a.adrSrc, a.irWrite, a.pcWrite, a.regWrite,
                 a.resultSrc, a.aluSrcA, a.aluSrcB, a.immSrc, a.aluControl, a.illegal,
                 e.st, e.memReq, e.memWrite, e.adrSrc, e.irWrite, e.pcWrite, e.regWrite,
                 e.resultSrc, e.aluSrcA, e.aluSrcB, e.immSrc, e.aluControl, e.illegal);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [0:5];
    logic [6:0] o;
    logic [2:0] f3;
    ops[0] = OP_LOAD;  ops[1] = OP_STORE;  ops[2] = OP_RTYPE;
    ops[3] = OP_ITYPE; ops[4] = OP_BRANCH; ops[5] = OP_JAL;

    bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.zero = 1'b0; bus.memReady = 1'b0;

    doReset(3, "power-on-reset");

    runInstr(OP_RTYPE,  3'b000, 1'b0, 0, 0, 1'b0, 0,  "add");
    runInstr(OP_RTYPE,  3'b000, 1'b1, 0, 0, 1'b0, 0,  "sub");
    runInstr(OP_RTYPE,  3'b001, 1'b1, 0, 0, 1'b0, 10, "sll-f7");
    runInstr(OP_ITYPE,  3'b000, 1'b1, 1, 0, 1'b0, 0,  "addi-f7");
    runInstr(OP_ITYPE,  3'b101, 1'b0, 0, 0, 1'b0, 3,  "srli");
    runInstr(OP_LOAD,   3'b010, 1'b0, 0, 3, 1'b0, 0,  "lw-stall3");
    runInstr(OP_BRANCH, 3'b000, 1'b0, 0, 0, 1'b1, 0,  "beq-taken");
    runInstr(OP_BRANCH, 3'b000, 1'b0, 0, 0, 1'b0, 0,  "beq-not-taken");
    runInstr(OP_BRANCH, 3'b001, 1'b0, 0, 0, 1'b0, 2,  "bne");
    runInstr(OP_STORE,  3'b010, 1'b0, 2, 0, 1'b0, 0,  "sw");
    runInstr(OP_JAL,    3'b000, 1'b0, 0, 0, 1'b0, 0,  "jal");
    runInstr(7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, 2, "bad-op");

    // Store aborted by reset in the middle of a memory stall.
    cOp = OP_STORE; cF3 = 3'b010; cF7 = 1'b0;
    st(0, 1'b1, 1'b0, 4'd0, 2'd0, "sw-abort/fetch");
    st(1, 1'b0, 1'b0, 4'd0, 2'd0, "sw-abort/decode");
    st(2, 1'b0, 1'b0, 4'd0, 2'b01, "sw-abort/memadr");
    st(5, 1'b0, 1'b0, 4'd0, 2'd0, "sw-abort/memwrite-wait");
    step(1'b0, 1'b0, 1'b1, expOut(0, 1'b0, 1'b0, 4'd0, 2'd0), "sw-abort/reset-in-stall");
    doReset(1, "sw-abort/reset-hold");
    runInstr(OP_RTYPE, 3'b111, 1'b0, 0, 0, 1'b0, 0, "and-after-reset");

    for (int n = 0; n < 80; n++) begin
      int k;
      k = int'($urandom_range(0, 6));
      o = (k == 6) ? 7'($urandom) : ops[k];
      f3 = 3'($urandom);
      if (o == OP_BRANCH && rb()) f3 = 3'b000;
      runInstr(o, f3, rb(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
               rb(), int'($urandom_range(1, 4)), $sformatf("rand%0d", n));
    end

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk, reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- memReady  in  1  memory access complete this cycle
- memReq  out  1  memory access request
- memWrite  out  1  store strobe
- adrSrc  out  1  0=PC, 1=ALUOut
- irWrite  out  1  latch instruction and oldPC
- pcWrite  out  1  PC enable
- regWrite  out  1  register-file write enable
- resultSrc  out  2  00=ALUOut, 01=memData, 10=aluResult
- aluSrcA  out  2  00=PC, 01=oldPC, 10=rs1
- aluSrcB  out  2  00=rs2, 01=imm, 10=constant 4
- immSrc  out  2  00=I, 01=S, 10=B, 11=J
- aluControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLL
- illegalInstr  out  1  sticky illegal-instruction flag
- stateOut  out  4  current state code, for debug

Function
REQ-003 The block SHALL be a Moore FSM with Mealy gating only on memReady and zero, using these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, ILLEGAL=15.
REQ-004 Every output not listed for a state SHALL be 0.
REQ-005 FETCH SHALL drive memReq=1, adrSrc=0, aluSrcA=00, aluSrcB=10, aluControl=ADD and resultSrc=10.
REQ-006 In FETCH, irWrite and pcWrite SHALL equal memReady, the FSM SHALL hold while memReady=0, and it SHALL go to DECODE on memReady=1.
REQ-007 DECODE SHALL drive aluSrcA=01, aluSrcB=01, immSrc=10 and ADD to precompute the branch target.
REQ-008 DECODE SHALL branch on op: 0000011 or 0100011 to MEMADR, 0110011 to EXECUTER, 0010011 to EXECUTEI, 1100011 to BEQ, 1101111 to JAL, and any other op to ILLEGAL.
REQ-009 DECODE SHALL also go to ILLEGAL on an unsupported funct3/funct7b5 combination, as defined in REQ-015 and REQ-016.
REQ-010 MEMADR SHALL drive aluSrcA=10, aluSrcB=01, ADD, and immSrc=00 for a load or 01 for a store, then go to MEMREAD for a load or MEMWRITE for a store.
REQ-011 MEMREAD SHALL drive memReq=1 and adrSrc=1, hold until memReady=1, then go to MEMWB.
REQ-012 MEMWB SHALL drive resultSrc=01 and regWrite=1, then go to FETCH.
REQ-013 MEMWRITE SHALL drive memReq=1, adrSrc=1 and memWrite=1 until memReady=1, then go to FETCH.
REQ-014 EXECUTER SHALL drive aluSrcA=10, aluSrcB=00 and decoded aluControl, then go to ALUWB; EXECUTEI SHALL do the same with aluSrcB=01 and immSrc=00.
REQ-015 The R-type decode SHALL be: funct3 000 with funct7b5=0 gives ADD, and with funct7b5=1 gives SUB; 111 gives AND; 110 gives OR; 001 with funct7b5=0 gives SLL; every other combination is illegal.
REQ-016 The I-type decode SHALL be: 000 gives ADD, 111 gives AND, 110 gives OR, 001 with funct7b5=0 gives SLL; every other combination is illegal, and funct7b5 SHALL be ignored except for 001.
REQ-017 ALUWB SHALL drive resultSrc=00 and regWrite=1, then go to FETCH.
REQ-018 BEQ SHALL drive aluSrcA=10, aluSrcB=00, SUB, resultSrc=00 and pcWrite=zero, then go to FETCH unconditionally; any funct3 other than 000 SHALL be illegal.
REQ-019 JAL SHALL drive aluSrcA=01, aluSrcB=10, ADD, resultSrc=00, immSrc=11 and pcWrite=1, then go to ALUWB.
REQ-020 ILLEGAL SHALL hold illegalInstr=1 with all strobes 0 and SHALL remain in ILLEGAL until reset.
REQ-021 Instruction latency SHALL be 3 cycles for beq, 4 for R/I/sw/jal and 5 for lw, each counted with zero memory wait cycles; every cycle with memReady=0 in a memory state SHALL add one cycle.
REQ-022 memWrite and memReq SHALL never assert outside FETCH, MEMREAD and MEMWRITE.
REQ-023 regWrite and pcWrite SHALL never assert in the same cycle as memWrite.

Reset
REQ-024 While reset=1, the FSM SHALL be in FETCH and illegalInstr SHALL be 0, independent of clk.
REQ-025 While reset=1, all strobes (memWrite, irWrite, pcWrite, regWrite) SHALL be 0.
REQ-026 After reset is released, the first FETCH request SHALL be issued on the next cycle.
REQ-027 A reset asserted mid-instruction, including during a memReady stall, SHALL abort that instruction with no further strobes.

Verification
REQ-028 add, op=0110011, f3=000, f7b5=0, memReady=1 -> states 0,1,6,8,0; aluControl=0000 in EXECUTER; regWrite=1 only in ALUWB.
REQ-029 sub, f7b5=1 -> aluControl=0001 in EXECUTER; sll with f7b5=1 -> ILLEGAL and illegalInstr=1, held through 10 cycles.
REQ-030 lw with memReady low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with resultSrc=01 and regWrite=1.
REQ-031 beq with zero=1 -> pcWrite=1 in BEQ; with zero=0 -> pcWrite=0; next state FETCH in both cases.
REQ-032 sw followed by jal -> memWrite=1 only in MEMWRITE; JAL gives pcWrite=1 and immSrc=11, then ALUWB with regWrite=1.
REQ-033 reset pulsed during a MEMWRITE stall -> memWrite drops immediately; after release, stateOut=0 and memReq=1 next cycle.
